// File: rtl/fpu_bus_if_pkg.sv
// Shared types and constants for the byte-wide host interface in front of the fpu core.
package pa_fpu;

  typedef enum logic [1:0] {
    op_add = 2'd0,
    op_sub = 2'd1,
    op_mul = 2'd2,
    op_div = 2'd3
  } e_fpu_op;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } e_fpu_if_state;

  // Field order puts busy at bit 0 and res_sign at bit 7 of the STATUS byte.
  typedef struct packed {
    logic res_sign;
    logic res_nan;
    logic res_inf;
    logic res_zero;
    logic err_busy;
    logic err_cmd;
    logic done;
    logic busy;
  } st_fpu_status;

  localparam logic [3:0] ADDR_A0     = 4'h0;
  localparam logic [3:0] ADDR_A1     = 4'h1;
  localparam logic [3:0] ADDR_A2     = 4'h2;
  localparam logic [3:0] ADDR_A3     = 4'h3;
  localparam logic [3:0] ADDR_B0     = 4'h4;
  localparam logic [3:0] ADDR_B1     = 4'h5;
  localparam logic [3:0] ADDR_B2     = 4'h6;
  localparam logic [3:0] ADDR_B3     = 4'h7;
  localparam logic [3:0] ADDR_CMD    = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'h9;
  localparam logic [3:0] ADDR_SETTLE = 4'hA;
  localparam logic [3:0] ADDR_RSVD   = 4'hB;
  localparam logic [3:0] ADDR_RES0   = 4'hC;
  localparam logic [3:0] ADDR_RES1   = 4'hD;
  localparam logic [3:0] ADDR_RES2   = 4'hE;
  localparam logic [3:0] ADDR_RES3   = 4'hF;

  localparam int unsigned ST_BUSY     = 0;
  localparam int unsigned ST_DONE     = 1;
  localparam int unsigned ST_ERR_CMD  = 2;
  localparam int unsigned ST_ERR_BUSY = 3;
  localparam int unsigned ST_RES_ZERO = 4;
  localparam int unsigned ST_RES_INF  = 5;
  localparam int unsigned ST_RES_NAN  = 6;
  localparam int unsigned ST_RES_SIGN = 7;

  function automatic e_fpu_op cmd_to_op(input logic [1:0] i_sel);
    e_fpu_op w_op;
    case (i_sel)
      2'd0:    w_op = op_add;
      2'd1:    w_op = op_sub;
      2'd2:    w_op = op_mul;
      2'd3:    w_op = op_div;
      default: w_op = op_add;
    endcase
    return w_op;
  endfunction

endpackage

// File: rtl/fpu_bus_if_classify.sv
// Combinational IEEE-754 single-precision classifier: zero, infinity, NaN and sign.
module fpu_classify (
  input  logic [31:0] i_ieee,
  output logic        o_zero,
  output logic        o_inf,
  output logic        o_nan,
  output logic        o_sign
);

  logic [7:0]  w_exp;
  logic [22:0] w_man;

  assign w_exp  = i_ieee[30:23];
  assign w_man  = i_ieee[22:0];
  assign o_zero = (w_exp == 8'h00) && (w_man == 23'd0);
  assign o_inf  = (w_exp == 8'hFF) && (w_man == 23'd0);
  assign o_nan  = (w_exp == 8'hFF) && (w_man != 23'd0);
  assign o_sign = i_ieee[31];

endmodule

// File: rtl/fpu_bus_if.sv
// Register-mapped 8-bit CPU interface that sequences one fpu operation:
// load operands, hold them for a settle window, capture and classify the result.
module fpu_bus_if
  import pa_fpu::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter logic        IRQ_EN_DEFAULT = 1'b1
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [3:0]  bus_addr,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        irq,
  output logic [31:0] a_operand,
  output logic [31:0] b_operand,
  output e_fpu_op     operation,
  input  logic [31:0] ieee_packet_out
);

  localparam logic [7:0] SETTLE_BYTE = 8'(SETTLE_CYCLES);
  localparam logic [7:0] CNT_INIT    = 8'(SETTLE_CYCLES - 1);

  e_fpu_if_state r_state, w_state_nxt;
  logic [7:0]    r_cnt, w_cnt_nxt;
  logic [31:0]   r_a, w_a_nxt;
  logic [31:0]   r_b, w_b_nxt;
  logic [31:0]   r_res, w_res_nxt;
  e_fpu_op       r_op, w_op_nxt;
  logic          r_irq_en, w_irq_en_nxt;
  st_fpu_status  r_status, w_status_nxt;
  logic [7:0]    r_rd_data, w_rd_data_nxt;
  logic          r_irq, w_irq_nxt;

  logic w_rd_en;
  logic w_wr_ctl;
  logic w_cls_zero, w_cls_inf, w_cls_nan, w_cls_sign;

  fpu_classify u_classify (
    .i_ieee (ieee_packet_out),
    .o_zero (w_cls_zero),
    .o_inf  (w_cls_inf),
    .o_nan  (w_cls_nan),
    .o_sign (w_cls_sign)
  );

  assign w_rd_en  = bus_rd && !bus_wr;
  assign w_wr_ctl = bus_wr && (bus_addr <= ADDR_CMD);

  // Next-state, register-file and read-data decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_res_nxt     = r_res;
    w_op_nxt      = r_op;
    w_irq_en_nxt  = r_irq_en;
    w_status_nxt  = r_status;
    w_rd_data_nxt = r_rd_data;

    if (w_rd_en) begin
      case (bus_addr)
        ADDR_A0, ADDR_A1, ADDR_A2, ADDR_A3:
          w_rd_data_nxt = r_a[{bus_addr[1:0], 3'b000} +: 8];
        ADDR_B0, ADDR_B1, ADDR_B2, ADDR_B3:
          w_rd_data_nxt = r_b[{bus_addr[1:0], 3'b000} +: 8];
        ADDR_STATUS:  w_rd_data_nxt = r_status;
        ADDR_SETTLE:  w_rd_data_nxt = SETTLE_BYTE;
        ADDR_RES0, ADDR_RES1, ADDR_RES2, ADDR_RES3:
          w_rd_data_nxt = r_res[{bus_addr[1:0], 3'b000} +: 8];
        default:      w_rd_data_nxt = 8'h00;
      endcase
      // Read-clear comes first so a capture on the same edge still sets done.
      if (bus_addr == ADDR_STATUS) begin
        w_status_nxt.done     = 1'b0;
        w_status_nxt.err_busy = 1'b0;
      end else begin
        w_status_nxt.done     = w_status_nxt.done;
      end
    end else begin
      w_rd_data_nxt = r_rd_data;
    end

    case (r_state)
      IDLE: begin
        if (bus_wr) begin
          case (bus_addr)
            ADDR_A0, ADDR_A1, ADDR_A2, ADDR_A3:
              w_a_nxt[{bus_addr[1:0], 3'b000} +: 8] = bus_data_in;
            ADDR_B0, ADDR_B1, ADDR_B2, ADDR_B3:
              w_b_nxt[{bus_addr[1:0], 3'b000} +: 8] = bus_data_in;
            ADDR_CMD: begin
              w_irq_en_nxt = bus_data_in[7];
              if (bus_data_in[6:2] == 5'd0) begin
                w_op_nxt              = cmd_to_op(bus_data_in[1:0]);
                w_status_nxt.done     = 1'b0;
                w_status_nxt.err_cmd  = 1'b0;
                w_status_nxt.err_busy = 1'b0;
                w_status_nxt.busy     = 1'b1;
                w_cnt_nxt             = CNT_INIT;
                w_state_nxt           = SETTLE;
              end else begin
                w_status_nxt.err_cmd  = 1'b1;
              end
            end
            default: w_a_nxt = r_a;
          endcase
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETTLE: begin
        if (w_wr_ctl) begin
          w_status_nxt.err_busy = 1'b1;
        end else begin
          w_status_nxt.err_busy = w_status_nxt.err_busy;
        end
        if (r_cnt == 8'd0) begin
          w_state_nxt = CAPTURE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      CAPTURE: begin
        if (w_wr_ctl) begin
          w_status_nxt.err_busy = 1'b1;
        end else begin
          w_status_nxt.err_busy = w_status_nxt.err_busy;
        end
        w_res_nxt             = ieee_packet_out;
        w_status_nxt.res_zero = w_cls_zero;
        w_status_nxt.res_inf  = w_cls_inf;
        w_status_nxt.res_nan  = w_cls_nan;
        w_status_nxt.res_sign = w_cls_sign;
        w_status_nxt.busy     = 1'b0;
        w_status_nxt.done     = 1'b1;
        w_state_nxt           = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_irq_nxt = w_status_nxt.done & w_irq_en_nxt;
  end

  // State and register file, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_res     <= 32'd0;
      r_op      <= op_add;
      r_irq_en  <= IRQ_EN_DEFAULT;
      r_status  <= '0;
      r_rd_data <= 8'h00;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_res     <= w_res_nxt;
      r_op      <= w_op_nxt;
      r_irq_en  <= w_irq_en_nxt;
      r_status  <= w_status_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_irq     <= w_irq_nxt;
    end
  end

  assign bus_data_out = r_rd_data;
  assign irq          = r_irq;
  assign a_operand    = r_a;
  assign b_operand    = r_b;
  assign operation    = r_op;

endmodule

// File: tb/tb_fpu_bus_if.sv
// Self-checking bench for fpu_bus_if: a transaction-level model of the register map
// is compared with the DUT every cycle; directed cases pin literal results.
module tb_fpu_bus_if;
  import pa_fpu::*;

  localparam int S = 4;

  logic        clk;
  logic        arst_n;
  logic [3:0]  bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic        irq;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  e_fpu_op     operation;
  logic [31:0] ieee_packet_out;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  // Model state
  logic [31:0] m_a, m_b, m_res;
  logic [1:0]  m_op;
  logic        m_irq_en, m_done, m_err_cmd, m_err_busy;
  logic        m_zero, m_inf, m_nan, m_sign;
  int          m_pend;
  logic [7:0]  m_rd;

  logic [7:0] specials [6] = '{8'h00, 8'h80, 8'h7f, 8'hff, 8'hc0, 8'h3f};

  fpu_bus_if #(.SETTLE_CYCLES(S), .IRQ_EN_DEFAULT(1'b1)) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .bus_addr        (bus_addr),
    .bus_wr          (bus_wr),
    .bus_rd          (bus_rd),
    .bus_data_in     (bus_data_in),
    .bus_data_out    (bus_data_out),
    .irq             (irq),
    .a_operand       (a_operand),
    .b_operand       (b_operand),
    .operation       (operation),
    .ieee_packet_out (ieee_packet_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in fpu core: known vectors give real IEEE results, anything else a cheap mix.
  function automatic logic [31:0] fake_fpu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
    if (op == 2'd0 && a == 32'h3f800000 && b == 32'h3f8ccccd) return 32'h40066666;
    if (op == 2'd2 && a == 32'h41800000 && b == 32'h42000000) return 32'h44000000;
    if (op == 2'd1 && a == 32'h7f800000 && b == 32'h7f800000) return 32'h7fc00000;
    if (op == 2'd0 && a == 32'h41800000 && b == 32'h42000000) return 32'h42400000;
    case (op)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  assign ieee_packet_out = fake_fpu(a_operand, b_operand, 2'(operation));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 32'd0; m_b = 32'd0; m_res = 32'd0; m_op = 2'd0;
    m_irq_en = 1'b1; m_done = 1'b0; m_err_cmd = 1'b0; m_err_busy = 1'b0;
    m_zero = 1'b0; m_inf = 1'b0; m_nan = 1'b0; m_sign = 1'b0;
    m_pend = 0; m_rd = 8'h00;
  endtask

  function automatic logic [7:0] m_status();
    return {m_sign, m_nan, m_inf, m_zero, m_err_busy, m_err_cmd, m_done, (m_pend != 0)};
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] addr);
    logic [31:0] t;
    if (addr <= 4'h3) begin
      t = m_a >> (8 * int'(addr[1:0]));
      return t[7:0];
    end
    if (addr <= 4'h7) begin
      t = m_b >> (8 * int'(addr[1:0]));
      return t[7:0];
    end
    if (addr == 4'h9) return m_status();
    if (addr == 4'hA) return 8'(S);
    if (addr >= 4'hC) begin
      t = m_res >> (8 * int'(addr[1:0]));
      return t[7:0];
    end
    return 8'h00;
  endfunction

  // One clock edge of the register map, applied to the model.
  task automatic model_step(input logic wr, input logic rd, input logic [3:0] addr,
                            input logic [7:0] d);
    logic was_busy;
    was_busy = (m_pend != 0);
    if (rd && !wr) begin
      m_rd = m_read(addr);
      if (addr == 4'h9) begin
        m_done = 1'b0;
        m_err_busy = 1'b0;
      end
    end
    if (wr) begin
      if (was_busy) begin
        if (addr <= 4'h8) m_err_busy = 1'b1;
      end else if (addr <= 4'h3) begin
        m_a[8*int'(addr[1:0]) +: 8] = d;
      end else if (addr <= 4'h7) begin
        m_b[8*int'(addr[1:0]) +: 8] = d;
      end else if (addr == 4'h8) begin
        m_irq_en = d[7];
        if (d[6:2] == 5'd0) begin
          m_op = d[1:0];
          m_done = 1'b0; m_err_cmd = 1'b0; m_err_busy = 1'b0;
          m_pend = S + 1;
        end else begin
          m_err_cmd = 1'b1;
        end
      end
    end
    if (was_busy) begin
      m_pend = m_pend - 1;
      if (m_pend == 0) begin
        m_res  = fake_fpu(m_a, m_b, m_op);
        m_zero = (m_res[30:23] == 8'h00) && (m_res[22:0] == 23'd0);
        m_inf  = (m_res[30:23] == 8'hff) && (m_res[22:0] == 23'd0);
        m_nan  = (m_res[30:23] == 8'hff) && (m_res[22:0] != 23'd0);
        m_sign = m_res[31];
        m_done = 1'b1;
      end
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_dout", 32'(bus_data_out), 32'(m_rd));
      chk("cyc_irq", 32'(irq), 32'(m_done & m_irq_en));
      chk("cyc_a", a_operand, m_a);
      chk("cyc_b", b_operand, m_b);
      chk("cyc_op", 32'(operation), 32'(m_op));
    end
  end

  task automatic cycle(input logic wr, input logic rd, input logic [3:0] addr,
                       input logic [7:0] d);
    bus_wr = wr; bus_rd = rd; bus_addr = addr; bus_data_in = d;
    @(posedge clk);
    model_step(wr, rd, addr, d);
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] d);
    cycle(1'b1, 1'b0, addr, d);
  endtask

  task automatic rd(input logic [3:0] addr, output logic [7:0] d);
    cycle(1'b0, 1'b1, addr, 8'h00);
    d = bus_data_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic write32(input logic [3:0] base, input logic [31:0] v);
    for (int i = 0; i < 4; i++) wr(base + 4'(i), v[8*i +: 8]);
  endtask

  task automatic read32(input logic [3:0] base, output logic [31:0] v);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      rd(base + 4'(i), b);
      v[8*i +: 8] = b;
    end
  endtask

  initial begin
    logic [7:0]  s;
    logic [31:0] v;
    logic [7:0]  d;
    logic [3:0]  a;
    int          r;

    bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = 4'h0; bus_data_in = 8'h00;
    arst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(bus_data_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_a", a_operand, 32'h0);
    chk("rst_op", 32'(operation), 32'(op_add));
    #2 arst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Add 1.0 + 1.1 with interrupts enabled
    write32(4'h0, 32'h3f800000);
    write32(4'h4, 32'h3f8ccccd);
    wr(4'h8, 8'h80);
    rd(4'h9, s);  chk("t1_busy_early", 32'(s), 32'h01);
    idle(S - 2);
    rd(4'h9, s);  chk("t1_busy_late", 32'(s), 32'h01);
    chk("t1_irq_before", 32'(irq), 32'h0);
    idle(1);
    chk("t1_irq_done", 32'(irq), 32'h1);
    read32(4'hC, v); chk("t1_result", v, 32'h40066666);
    rd(4'h9, s);  chk("t1_status", 32'(s), 32'h02);
    chk("t1_irq_clr", 32'(irq), 32'h0);

    // Multiply 16 x 32
    write32(4'h0, 32'h41800000);
    write32(4'h4, 32'h42000000);
    wr(4'h8, 8'h82);
    idle(S + 1);
    chk("t2_irq", 32'(irq), 32'h1);
    read32(4'hC, v); chk("t2_result", v, 32'h44000000);
    rd(4'h9, s);  chk("t2_status", 32'(s), 32'h02);
    chk("t2_irq_clr", 32'(irq), 32'h0);

    // inf - inf gives a quiet NaN
    write32(4'h0, 32'h7f800000);
    write32(4'h4, 32'h7f800000);
    wr(4'h8, 8'h81);
    idle(S + 1);
    read32(4'hC, v); chk("t3_result", v, 32'h7fc00000);
    rd(4'h9, s);  chk("t3_status", 32'(s), 32'h42);

    // Write while busy is dropped and flagged
    write32(4'h0, 32'h41800000);
    write32(4'h4, 32'h42000000);
    wr(4'h8, 8'h82);
    idle(1);
    wr(4'h0, 8'h55);
    idle(S - 1);
    chk("t4_a_kept", a_operand, 32'h41800000);
    read32(4'hC, v); chk("t4_result", v, 32'h44000000);
    rd(4'h9, s);  chk("t4_status", 32'(s), 32'h0A);

    // Bad command
    wr(4'h8, 8'h14);
    rd(4'h9, s);  chk("t5_status", 32'(s), 32'h04);
    chk("t5_op", 32'(operation), 32'(op_mul));
    chk("t5_irq", 32'(irq), 32'h0);

    // Misc map: SETTLE, reserved, simultaneous write/read, read-only write
    rd(4'hA, s);  chk("settle_reg", 32'(s), 32'(S));
    rd(4'hB, s);  chk("rsvd_reg", 32'(s), 32'h00);
    cycle(1'b1, 1'b1, 4'h0, 8'h77);
    chk("wr_rd_dout", 32'(bus_data_out), 32'h00);
    chk("wr_rd_a", 32'(a_operand[7:0]), 32'h77);
    wr(4'hC, 8'hAA);
    rd(4'hC, s);  chk("ro_result", 32'(s), 32'h00);

    // Reset during SETTLE
    wr(4'h8, 8'h82);
    idle(2);
    #2 arst_n = 1'b0;
    #1 model_reset();
    chk("t6_a", a_operand, 32'h0);
    chk("t6_irq", 32'(irq), 32'h0);
    chk("t6_op", 32'(operation), 32'(op_add));
    @(negedge clk);
    #2 arst_n = 1'b1;
    rd(4'h9, s);  chk("t6_status", 32'(s), 32'h00);
    read32(4'hC, v); chk("t6_res_clr", v, 32'h0);
    write32(4'h0, 32'h41800000);
    write32(4'h4, 32'h42000000);
    wr(4'h8, 8'h80);
    idle(S + 1);
    read32(4'hC, v); chk("t6_result", v, 32'h42400000);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      if (a <= 4'h7 && $urandom_range(0, 1) == 0) d = specials[$urandom_range(0, 5)];
      if (a == 4'h8 && $urandom_range(0, 3) != 0) d[6:2] = 5'd0;
      if (r < 30)      cycle(1'b1, 1'b0, a, d);
      else if (r < 55) cycle(1'b0, 1'b1, a, d);
      else if (r < 60) cycle(1'b1, 1'b1, a, d);
      else             cycle(1'b0, 1'b0, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
